// File: rtl/reseller_pkg.sv
// Shared vending-datapath definitions: payout FSM state encoding and default coin denominations.
package reseller_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_EJECT  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SELECT = ST_SELECT,
        S_EJECT  = ST_EJECT,
        S_GAP    = ST_GAP,
        S_DONE   = ST_DONE,
        S_FAULT  = ST_FAULT
    } state_t;

    localparam int COIN_HI_DEFAULT = 5;
    localparam int COIN_LO_DEFAULT = 1;

endpackage

// File: rtl/dispense_timer.sv
// Wait counter for the EJECT state; tc flags the last permitted cycle before a hopper timeout.
module dispense_timer #(
    parameter int LIMIT = 1023,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/change_dispenser.sv
// Change-return controller: pays out the owed amount one coin at a time over a req/ack hopper handshake.
// Optional hopper timeout and sticky fault are built only when DISPENSE_TIMEOUT_EN is defined.
module change_dispenser
    import reseller_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int COIN_HI        = COIN_HI_DEFAULT,
    parameter int COIN_LO        = COIN_LO_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] amount,
    output logic             eject_hi,
    output logic             eject_lo,
    input  logic             eject_ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining,
    output logic [WIDTH-1:0] coin_cnt,
    output logic             fault
);

    localparam logic [WIDTH-1:0] HI_V = WIDTH'(COIN_HI);
    localparam logic [WIDTH-1:0] LO_V = WIDTH'(COIN_LO);

    if (COIN_LO < 1 || COIN_HI < COIN_LO || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("change_dispenser: invalid coin or timeout parameters");
    end

    state_t state;

`ifdef DISPENSE_TIMEOUT_EN
    logic tmo_tc;
    logic fault_q;

    dispense_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state == S_SELECT),
        .en  (state == S_EJECT),
        .tc  (tmo_tc)
    );

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            eject_hi  <= 1'b0;
            eject_lo  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            coin_cnt  <= '0;
`ifdef DISPENSE_TIMEOUT_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        coin_cnt  <= '0;
                        busy      <= 1'b1;
                        // Nothing owed: skip straight to the completion pulse.
                        if (amount == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (remaining >= HI_V)
                        eject_hi <= 1'b1;
                    else
                        eject_lo <= 1'b1;
                    state <= S_EJECT;
                end
                S_EJECT: begin
                    if (eject_ack) begin
                        remaining <= remaining - (eject_hi ? HI_V : LO_V);
                        coin_cnt  <= coin_cnt + 1'b1;
                        eject_hi  <= 1'b0;
                        eject_lo  <= 1'b0;
                        state     <= S_GAP;
                    end
`ifdef DISPENSE_TIMEOUT_EN
                    else if (tmo_tc) begin
                        eject_hi <= 1'b0;
                        eject_lo <= 1'b0;
                        busy     <= 1'b0;
                        fault_q  <= 1'b1;
                        state    <= S_FAULT;
                    end
`endif
                end
                S_GAP: begin
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; the timeout case runs only with DISPENSE_TIMEOUT_EN.
module tb_change_dispenser;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] amount;
    logic             eject_hi;
    logic             eject_lo;
    logic             eject_ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] coin_cnt;
    logic             fault;

    int n_checks = 0;
    int n_fails  = 0;

    change_dispenser #(
        .WIDTH(WIDTH), .COIN_HI(5), .COIN_LO(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount),
        .eject_hi(eject_hi), .eject_lo(eject_lo), .eject_ack(eject_ack),
        .busy(busy), .done(done), .remaining(remaining), .coin_cnt(coin_cnt),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_hi"}, eject_hi, 0);
        chk({tag, "_lo"}, eject_lo, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rem"}, remaining, 0);
        chk({tag, "_cnt"}, coin_cnt, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    // Accept a start; for a nonzero amount, returns with the first request visible.
    task automatic start_pay(input logic [WIDTH-1:0] amt);
        start  = 1'b1;
        amount = amt;
        tick();
        start  = 1'b0;
        amount = 8'hAA;
        chk("acc_busy", busy, 1);
        chk("acc_rem", remaining, amt);
        chk("acc_cnt", coin_cnt, 0);
        chk("acc_noreq", eject_hi | eject_lo, 0);
        if (amt != 0) tick();
    endtask

    // One coin: request visible on entry; holds for dly cycles, acks, then checks the gap.
    task automatic coin(input bit hi, input int rem_before, input int rem_after,
                        input int cnt, input int dly);
        chk("req_hi", eject_hi, hi);
        chk("req_lo", eject_lo, !hi);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("hold_req", hi ? eject_hi : eject_lo, 1);
            chk("hold_rem", remaining, rem_before);
        end
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        chk("ack_drop", eject_hi | eject_lo, 0);
        chk("ack_rem", remaining, rem_after);
        chk("ack_cnt", coin_cnt, cnt);
        chk("ack_nodone", done, 0);
        tick();
        chk("gap_noreq", eject_hi | eject_lo, 0);
        if (rem_after == 0) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            tick();
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_rem", remaining, 0);
        end else begin
            chk("gap_nodone", done, 0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; amount = '0; eject_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // amount 13: hi, hi, lo, lo, lo
        start_pay(8'd13);
        coin(1, 13, 8, 1, 1);
        coin(1, 8, 3, 2, 1);
        coin(0, 3, 2, 3, 1);
        coin(0, 2, 1, 4, 1);
        coin(0, 1, 0, 5, 1);
        chk("a13_cnt_hold", coin_cnt, 5);
        tick();
        chk("a13_idle_done", done, 0);
        chk("a13_idle_cnt", coin_cnt, 5);

        // stray ack in IDLE is ignored
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        chk("stray_ack_cnt", coin_cnt, 5);
        chk("stray_ack_req", eject_hi | eject_lo, 0);

        // zero amount
        start_pay(8'd0);
        chk("z_done", done, 1);
        tick();
        chk("z_done_low", done, 0);
        chk("z_busy_low", busy, 0);
        chk("z_noreq", eject_hi | eject_lo, 0);
        chk("z_cnt", coin_cnt, 0);

        // amount 5, ack delayed 20 cycles
        start_pay(8'd5);
        coin(1, 5, 0, 1, 20);

        // amount 9 with a second start (amount 50) held during the first coin
        start_pay(8'd9);
        start  = 1'b1;
        amount = 8'd50;
        coin(1, 9, 4, 1, 1);
        start  = 1'b0;
        amount = 8'hAA;
        coin(0, 4, 3, 2, 0);
        coin(0, 3, 2, 3, 0);
        coin(0, 2, 1, 4, 0);
        coin(0, 1, 0, 5, 0);
        chk("a9_cnt", coin_cnt, 5);

        // reset in the middle of EJECT for amount 7
        start_pay(8'd7);
        chk("a7_req", eject_hi, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        tick();
        chk("midrst_nodone", done, 0);
        chk("midrst_noreq", eject_hi | eject_lo, 0);
        chk("midrst_busy", busy, 0);

`ifdef DISPENSE_TIMEOUT_EN
        // hopper never acknowledges: fault after 16 EJECT cycles
        start_pay(8'd3);
        chk("tmo_req", eject_lo, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("tmo_wait_req", eject_lo, 1);
            chk("tmo_wait_fault", fault, 0);
        end
        tick();
        chk("tmo_drop", eject_hi | eject_lo, 0);
        chk("tmo_fault", fault, 1);
        chk("tmo_busy", busy, 0);
        start  = 1'b1;
        amount = 8'd4;
        tick();
        start  = 1'b0;
        tick();
        chk("flt_start_busy", busy, 0);
        chk("flt_start_req", eject_hi | eject_lo, 0);
        chk("flt_sticky", fault, 1);
        chk("flt_rem", remaining, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("flt_rst");
`else
        chk("nofault", fault, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
